rx_deserializer_sync: RTL and testbench



---
 rtl/rx_deserializer_sync_pkg.sv | 14 +
 rtl/rx_deserializer_sync_lane.sv | 91 +++++++++
 rtl/rx_deserializer_sync.sv | 48 ++++
 tb/tb_rx_deserializer_sync.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rx_deserializer_sync_pkg.sv
// rtl/rx_deserializer_sync_pkg.sv - shared constants for the HS receive deserializer
package rx_deserializer_sync_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] SYNC_WORD_DEFAULT = 8'hB8;

    typedef logic [1:0] lane_state_t;

    localparam lane_state_t LANE_IDLE    = 2'd0;
    localparam lane_state_t LANE_HUNT    = 2'd1;
    localparam lane_state_t LANE_ALIGNED = 2'd2;

endpackage

// File: rtl/rx_deserializer_sync_lane.sv
// rtl/rx_deserializer_sync_lane.sv - one lane: sync hunt, byte alignment and byte output
module rx_deser_lane
    import rx_deserializer_sync_pkg::*;
#(
    parameter logic [BYTE_W-1:0] SYNC_WORD    = SYNC_WORD_DEFAULT,
    parameter int                SYNC_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hs_en,
    input  logic              bit_data,
    output logic [BYTE_W-1:0] byte_data,
    output logic              byte_valid,
    output logic              sync_det,
    output logic              err_sot,
    output logic              aligned
);

    localparam int TW = $clog2(SYNC_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(SYNC_TIMEOUT);

    lane_state_t       state;
    logic [BYTE_W-1:0] sr;
    logic [BYTE_W-1:0] sr_next;
    logic [2:0]        bit_cnt;
    logic [TW-1:0]     to_cnt;
    logic [TW-1:0]     to_cnt_inc;

    // Bits arrive LSB-first, so each new bit enters at the MSB.
    assign sr_next    = {bit_data, sr[BYTE_W-1:1]};
    assign to_cnt_inc = to_cnt + 1'b1;
    assign aligned    = (state == LANE_ALIGNED);

    // Lane FSM with shift register, counters and registered outputs; dropping
    // hs_en wins over sync match and byte completion in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LANE_IDLE;
            sr         <= '0;
            bit_cnt    <= '0;
            to_cnt     <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            sync_det   <= 1'b0;
            err_sot    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            sync_det   <= 1'b0;
            if (!hs_en) begin
                state   <= LANE_IDLE;
                sr      <= '0;
                bit_cnt <= '0;
                to_cnt  <= '0;
                err_sot <= 1'b0;
            end else begin
                case (state)
                    LANE_IDLE: begin
                        state   <= LANE_HUNT;
                        to_cnt  <= '0;
                        err_sot <= 1'b0;
                    end
                    LANE_HUNT: begin
                        sr <= sr_next;
                        if (sr_next == SYNC_WORD) begin
                            sync_det <= 1'b1;
                            bit_cnt  <= '0;
                            state    <= LANE_ALIGNED;
                        end else if (to_cnt != TO_MAX) begin
                            to_cnt <= to_cnt_inc;
                            if (to_cnt_inc == TO_MAX) begin
                                err_sot <= 1'b1;
                            end
                        end
                    end
                    LANE_ALIGNED: begin
                        sr      <= sr_next;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_data  <= sr_next;
                            byte_valid <= 1'b1;
                        end
                    end
                    default: begin
                        state <= LANE_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/rx_deserializer_sync.sv
// rtl/rx_deserializer_sync.sv - multi-lane HS receive deserializer top
module rx_deserializer_sync
    import rx_deserializer_sync_pkg::*;
#(
    parameter int                NUM_LANES    = 4,
    parameter logic [BYTE_W-1:0] SYNC_WORD    = SYNC_WORD_DEFAULT,
    parameter int                SYNC_TIMEOUT = 64
) (
    input  logic                        bit_clk_i,
    input  logic                        reset_i,
    input  logic [NUM_LANES-1:0]        hs_en_i,
    input  logic [NUM_LANES-1:0]        bit_data_i,
    output logic [BYTE_W*NUM_LANES-1:0] byte_data_o,
    output logic [NUM_LANES-1:0]        byte_valid_o,
    output logic [NUM_LANES-1:0]        sync_det_o,
    output logic                        lanes_aligned_o,
    output logic [NUM_LANES-1:0]        err_sot_o
);

    logic [NUM_LANES-1:0] lane_aligned;

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        rx_deser_lane #(
            .SYNC_WORD    (SYNC_WORD),
            .SYNC_TIMEOUT (SYNC_TIMEOUT)
        ) u_lane (
            .clk        (bit_clk_i),
            .reset      (reset_i),
            .hs_en      (hs_en_i[n]),
            .bit_data   (bit_data_i[n]),
            .byte_data  (byte_data_o[BYTE_W*n +: BYTE_W]),
            .byte_valid (byte_valid_o[n]),
            .sync_det   (sync_det_o[n]),
            .err_sot    (err_sot_o[n]),
            .aligned    (lane_aligned[n])
        );
    end

    // Disabled lanes do not hold the flag down, but at least one lane must be enabled.
    always_ff @(posedge bit_clk_i) begin
        if (reset_i) begin
            lanes_aligned_o <= 1'b0;
        end else begin
            lanes_aligned_o <= (&(~hs_en_i | lane_aligned)) & (|hs_en_i);
        end
    end

endmodule

// File: tb/tb_rx_deserializer_sync.sv
// tb/tb_rx_deserializer_sync.sv - directed self-checking bench for rx_deserializer_sync
module tb_rx_deserializer_sync;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  hs_en;
    logic [3:0]  bit_data;
    logic [31:0] byte_data;
    logic [3:0]  byte_valid;
    logic [3:0]  sync_det;
    logic        lanes_aligned;
    logic [3:0]  err_sot;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          sync_cnt  [4];
    int          valid_cnt [4];
    int          last_vcyc [4];
    int          prev_vcyc [4];
    logic [7:0]  last_vdata[4];
    logic [7:0]  sw;
    logic [7:0]  pay [4];

    rx_deserializer_sync #(
        .NUM_LANES    (4),
        .SYNC_WORD    (8'hB8),
        .SYNC_TIMEOUT (64)
    ) dut (
        .bit_clk_i       (clk),
        .reset_i         (reset),
        .hs_en_i         (hs_en),
        .bit_data_i      (bit_data),
        .byte_data_o     (byte_data),
        .byte_valid_o    (byte_valid),
        .sync_det_o      (sync_det),
        .lanes_aligned_o (lanes_aligned),
        .err_sot_o       (err_sot)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        for (int l = 0; l < 4; l++) begin
            sync_cnt[l]   = 0;
            valid_cnt[l]  = 0;
            last_vcyc[l]  = 0;
            prev_vcyc[l]  = 0;
            last_vdata[l] = 8'h00;
        end
    endtask

    task automatic tick(input logic [3:0] bits);
        bit_data = bits;
        @(posedge clk);
        #1;
        cyc++;
        for (int l = 0; l < 4; l++) begin
            if (sync_det[l]) sync_cnt[l]++;
            if (byte_valid[l]) begin
                valid_cnt[l]++;
                last_vdata[l] = byte_data[8*l +: 8];
                prev_vcyc[l]  = last_vcyc[l];
                last_vcyc[l]  = cyc;
            end
        end
    endtask

    task automatic send_byte0(input logic [7:0] b);
        for (int i = 0; i < 8; i++) tick({3'b000, b[i]});
    endtask

    function automatic logic lane_bit(input int l, input int t);
        int u;
        logic [7:0] p;
        p = pay[l];
        u = t - ((l == 2) ? 3 : 0);
        if (u < 0)  return 1'b0;
        if (u < 8)  return sw[u];
        if (u < 16) return p[u-8];
        return 1'b0;
    endfunction

    initial begin
        logic [3:0] mb;
        sw     = 8'hB8;
        pay[0] = 8'hC3;
        pay[1] = 8'h96;
        pay[2] = 8'h7E;
        pay[3] = 8'h0F;
        reset    = 1'b1;
        hs_en    = 4'h0;
        bit_data = 4'h0;
        clr_stats();

        // reset with random inputs
        for (int i = 0; i < 4; i++) begin
            hs_en = 4'($urandom);
            tick(4'($urandom));
            check_eq("reset_outs", {byte_data, byte_valid, sync_det, lanes_aligned, err_sot}, 64'd0);
        end
        reset = 1'b0;
        hs_en = 4'h0;
        for (int i = 0; i < 3; i++) begin
            tick(4'($urandom));
            check_eq("idle_outs", {byte_data, byte_valid, sync_det, lanes_aligned, err_sot}, 64'd0);
        end

        // lane 0 alone: noise, sync, 0x5A, 0x3C, 0xB8 payload
        hs_en = 4'b0001;
        tick(4'h0);
        clr_stats();
        tick(4'h1); tick(4'h0); tick(4'h1);
        send_byte0(8'hB8);
        check_eq("sync_pulse", {63'd0, sync_det[0]}, 64'd1);
        check_eq("sync_cnt1", sync_cnt[0], 1);
        send_byte0(8'h5A);
        check_eq("b5a_cnt", valid_cnt[0], 1);
        check_eq("b5a_data", last_vdata[0], 8'h5A);
        check_eq("b5a_latency", last_vcyc[0], cyc);
        check_eq("aligned_1lane", {63'd0, lanes_aligned}, 64'd1);
        send_byte0(8'h3C);
        check_eq("b3c_data", last_vdata[0], 8'h3C);
        check_eq("b3c_spacing", last_vcyc[0] - prev_vcyc[0], 8);
        send_byte0(8'hB8);
        check_eq("payload_b8_data", last_vdata[0], 8'hB8);
        check_eq("payload_b8_cnt", valid_cnt[0], 3);
        check_eq("payload_no_resync", sync_cnt[0], 1);
        tick(4'h1);
        check_eq("hold_data", byte_data[7:0], 8'hB8);
        check_eq("hold_novalid", {63'd0, byte_valid[0]}, 64'd0);

        // abort after 5 bits of a byte
        for (int i = 0; i < 4; i++) tick(4'h1);
        hs_en = 4'b0000;
        tick(4'h1);
        tick(4'h1);
        check_eq("abort5_cnt", valid_cnt[0], 3);
        check_eq("abort5_unaligned", {63'd0, lanes_aligned}, 64'd0);

        // re-enable and resync
        hs_en = 4'b0001;
        tick(4'h0);
        clr_stats();
        send_byte0(8'hB8);
        send_byte0(8'hA5);
        check_eq("resync_cnt", sync_cnt[0], 1);
        check_eq("resync_data", last_vdata[0], 8'hA5);
        check_eq("resync_vcnt", valid_cnt[0], 1);

        // drop hs_en in the same cycle as the eighth bit
        for (int i = 0; i < 7; i++) tick(4'h1);
        hs_en = 4'b0000;
        tick(4'h1);
        check_eq("abort8_suppressed", valid_cnt[0], 1);

        // sync timeout
        hs_en = 4'b0001;
        tick(4'h0);
        clr_stats();
        for (int i = 0; i < 63; i++) tick(4'h0);
        check_eq("timeout_63", {63'd0, err_sot[0]}, 64'd0);
        tick(4'h0);
        check_eq("timeout_64", {63'd0, err_sot[0]}, 64'd1);
        send_byte0(8'hB8);
        check_eq("timeout_sync", sync_cnt[0], 1);
        check_eq("timeout_sticky", {63'd0, err_sot[0]}, 64'd1);
        hs_en = 4'b0000;
        tick(4'h0);
        check_eq("timeout_clear", {60'd0, err_sot}, 64'd0);

        // four lanes, lane 2 three bits late
        hs_en = 4'b1111;
        tick(4'h0);
        clr_stats();
        for (int t = 0; t < 20; t++) begin
            for (int l = 0; l < 4; l++) mb[l] = lane_bit(l, t);
            tick(mb);
            if (t == 7) begin
                check_eq("ml_early_sync", {60'd0, sync_det}, 64'hB);
                check_eq("ml_not_aligned", {63'd0, lanes_aligned}, 64'd0);
            end
            if (t == 10) begin
                check_eq("ml_lane2_sync", {60'd0, sync_det}, 64'h4);
                check_eq("ml_still_low", {63'd0, lanes_aligned}, 64'd0);
            end
            if (t == 11) check_eq("ml_aligned_rise", {63'd0, lanes_aligned}, 64'd1);
        end
        for (int l = 0; l < 4; l++) begin
            check_eq($sformatf("ml_data%0d", l), last_vdata[l], pay[l]);
            check_eq($sformatf("ml_vcnt%0d", l), valid_cnt[l], 1);
        end
        check_eq("ml_lane2_lag", last_vcyc[2] - last_vcyc[0], 3);

        hs_en = 4'b0111;
        tick(4'h0);
        tick(4'h0);
        check_eq("ml_lane3_off", {63'd0, lanes_aligned}, 64'd1);
        hs_en = 4'b0000;
        tick(4'h0);
        check_eq("ml_all_off", {63'd0, lanes_aligned}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
